// File: rtl/uart_tx_block_serializer_if.sv
// rtl/uart_tx_block_serializer_if.sv - block-in / byte-out handshake bundle for uart_tx_block_serializer
interface uart_tx_block_serializer_if #(
  parameter int NUM_BYTES = 16
);
  // Upstream block side
  logic                   Block_DV_in;
  logic [8*NUM_BYTES-1:0] Block_in;
  logic                   Block_Ready_out;
  // UART transmitter side
  logic                   Tx_Active_in;
  logic                   Tx_Done_in;
  logic                   Tx_DV_out;
  logic [7:0]             Tx_Byte_out;
  // Status
  logic                   Busy_out;
  logic                   Block_Done_out;

  // Serializer view
  modport slave (
    input  Block_DV_in, Block_in, Tx_Active_in, Tx_Done_in,
    output Block_Ready_out, Tx_DV_out, Tx_Byte_out, Busy_out, Block_Done_out
  );

  // Driver / environment view
  modport master (
    output Block_DV_in, Block_in, Tx_Active_in, Tx_Done_in,
    input  Block_Ready_out, Tx_DV_out, Tx_Byte_out, Busy_out, Block_Done_out
  );
endinterface

// File: rtl/uart_tx_block_serializer.sv
// rtl/uart_tx_block_serializer.sv - splits a NUM_BYTES block into MSB-first UART bytes; TX_CHECKSUM_EN appends an XOR byte
module uart_tx_block_serializer #(
  parameter int NUM_BYTES = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  uart_tx_block_serializer_if.slave   bus
);
  localparam int W  = 8 * NUM_BYTES;
  localparam int CW = $clog2(NUM_BYTES + 2);
`ifdef TX_CHECKSUM_EN
  localparam int TOTAL = NUM_BYTES + 1;
  localparam logic [CW-1:0] NB_C = CW'(NUM_BYTES);
`else
  localparam int TOTAL = NUM_BYTES;
`endif
  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_DONE, WAIT_IDLE, FINISH} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            done_prev_q, done_prev_d;
  logic            fire;
  logic            done_rise;
  logic [7:0]      cur_byte;
`ifdef TX_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  // Byte to present next: payload MSB first, checksum once all payload bytes are out
`ifdef TX_CHECKSUM_EN
  assign cur_byte = (cnt_q == NB_C) ? csum_q : shift_q[W-1 -: 8];
`else
  assign cur_byte = shift_q[W-1 -: 8];
`endif

  assign done_rise = bus.Tx_Done_in && !done_prev_q;

  // Next-state and datapath decisions
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    tx_byte_d   = tx_byte_q;
    done_prev_d = bus.Tx_Done_in;
    fire        = 1'b0;
`ifdef TX_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.Block_DV_in) begin
          shift_d = bus.Block_in;
          cnt_d   = '0;
`ifdef TX_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
          state_d = SEND;
        end
      end
      SEND: begin
        if (!bus.Tx_Active_in && !bus.Tx_Done_in) begin
          fire      = 1'b1;
          tx_byte_d = cur_byte;
          // Arm the edge detector as if Done were high: a Done already high
          // on the first WAIT_DONE cycle is stale and must not count.
          done_prev_d = 1'b1;
`ifdef TX_CHECKSUM_EN
          if (cnt_q < NB_C) csum_d = csum_q ^ cur_byte;
`endif
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (done_rise) begin
          shift_d = shift_q << 8;
          cnt_d   = cnt_q + 1'b1;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (!bus.Tx_Done_in && !bus.Tx_Active_in)
          state_d = (cnt_q < TOTAL_C) ? SEND : FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      tx_byte_q   <= 8'h00;
      done_prev_q <= 1'b0;
`ifdef TX_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      tx_byte_q   <= tx_byte_d;
      done_prev_q <= done_prev_d;
`ifdef TX_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.Block_Ready_out = (state_q == IDLE) && !RST;
  assign bus.Tx_DV_out       = fire && !RST;
  assign bus.Tx_Byte_out     = RST ? 8'h00 : (fire ? cur_byte : tx_byte_q);
  assign bus.Busy_out        = (state_q != IDLE) && !RST;
  assign bus.Block_Done_out  = (state_q == FINISH) && !RST;
endmodule

// File: doc/uart_tx_block_serializer.md
UART_TX_BLOCK_SERIALIZER -- requirements
Module: uart_tx_block_serializer

Interface
REQ-001 The block SHALL have parameter NUM_BYTES, default 16, giving the number of payload bytes per block (block width = 8*NUM_BYTES).
REQ-002 The block SHALL have CLK, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have RST, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have Block_DV_in, input, 1 bit, upstream block valid.
REQ-005 The block SHALL have Block_in, input, 8*NUM_BYTES bits, the payload block (for example AES-128 ciphertext).
REQ-006 The block SHALL have Block_Ready_out, output, 1 bit, indicating that a new block can be accepted.
REQ-007 The block SHALL have Tx_Active_in, input, 1 bit, the busy flag from the UART transmitter.
REQ-008 The block SHALL have Tx_Done_in, input, 1 bit, the done flag from the UART transmitter; it is high for 1 or more cycles per byte.
REQ-009 The block SHALL have Tx_DV_out, output, 1 bit, a one-cycle byte-valid strobe to the transmitter.
REQ-010 The block SHALL have Tx_Byte_out, output, 8 bits, the byte presented to the transmitter.
REQ-011 The block SHALL have Busy_out, output, 1 bit, high whenever the state is not IDLE.
REQ-012 The block SHALL have Block_Done_out, output, 1 bit, a one-cycle pulse after the last byte of a block is transmitted.

Function
REQ-013 The FSM SHALL have states IDLE, SEND, WAIT_DONE, WAIT_IDLE and FINISH.
REQ-014 Block_Ready_out SHALL equal 1 exactly when the state is IDLE and RST is 0.
REQ-015 When Block_DV_in and Block_Ready_out are both high, the block SHALL capture Block_in into a shift register, clear the byte counter, and go to SEND.
REQ-016 Block_DV_in SHALL be ignored in every state other than IDLE.
REQ-017 Bytes SHALL be sent most-significant byte first: Block_in[8*NUM_BYTES-1 -: 8] first and Block_in[7:0] last.
REQ-018 In SEND, only when Tx_Active_in=0 and Tx_Done_in=0, the block SHALL drive Tx_DV_out=1 with the current byte on Tx_Byte_out for exactly one cycle, then go to WAIT_DONE. Otherwise it SHALL remain in SEND with Tx_DV_out=0.
REQ-019 Tx_Byte_out SHALL hold its value from the Tx_DV_out cycle until the next Tx_DV_out.
REQ-020 In WAIT_DONE, the block SHALL advance only on a rising edge of Tx_Done_in (current 1, previous cycle 0, using a registered copy); a Tx_Done_in that is already high on entry SHALL NOT count.
REQ-021 On that rising edge, the block SHALL shift the register by one byte, increment the byte counter, and go to WAIT_IDLE.
REQ-022 In WAIT_IDLE, once Tx_Done_in=0 and Tx_Active_in=0:
- if the counter is below the total byte count, the block SHALL go to SEND;
- otherwise it SHALL go to FINISH.
REQ-023 FINISH SHALL last one cycle with Block_Done_out=1, then go to IDLE.
REQ-024 The earliest next-block acceptance SHALL be the cycle after FINISH.
REQ-025 The byte counter SHALL be wide enough for NUM_BYTES+1 without wrap-around.
REQ-026 The minimum latency from acceptance to the first Tx_DV_out SHALL be 1 cycle.
REQ-027 Every other state encoding SHALL return to IDLE on the next cycle.

Reset
REQ-028 While RST=1, the block SHALL set the state to IDLE, Tx_DV_out=0, Tx_Byte_out=8'h00, Busy_out=0, Block_Done_out=0, counter=0, shift register=0, checksum=0, and the Tx_Done_in history bit=0.
REQ-029 Asserting RST mid-block SHALL discard the remaining bytes with no Block_Done_out pulse; a byte already handed to the transmitter is not recalled.

Configuration
REQ-030 With macro TX_CHECKSUM_EN defined, the block SHALL keep a running XOR of all payload bytes sent, cleared on block acceptance, and send it as byte NUM_BYTES+1 using the same SEND/WAIT handshake before FINISH.
REQ-031 Without TX_CHECKSUM_EN, exactly NUM_BYTES bytes SHALL be sent and no checksum logic SHALL exist.

Verification
REQ-032 Block_in=128'h00112233445566778899AABBCCDDEEFF with a model transmitter (Done high for 2 cycles) SHALL produce Tx_Byte_out 00,11,...,FF: 16 DV pulses and one Block_Done_out pulse; with TX_CHECKSUM_EN, a 17th byte 8'h00.
REQ-033 Block_in=128'h0102030405060708090A0B0C0D0E0F10 with TX_CHECKSUM_EN SHALL produce a 17th byte 8'h10.
REQ-034 Holding Tx_Active_in=1 for 500 cycles in SEND SHALL produce no Tx_DV_out until Tx_Active_in falls, then exactly one pulse.
REQ-035 Block_DV_in pulsed with a different block mid-transfer SHALL be ignored, with the original byte sequence unchanged.
REQ-036 RST asserted after byte 5's DV SHALL give, next cycle, IDLE, Block_Ready_out=1 and no Block_Done_out; a new block SHALL then send from its byte 0.
REQ-037 Tx_Done_in stuck high on entry to WAIT_DONE SHALL NOT advance the FSM until Tx_Done_in falls and rises again.
